// File: rtl/neural_frame_gate.sv
// Whole-frame admission gate between the SPI frame stream and the data FIFO write port.
// Locks on the 64-bit magic header and admits or drops each frame as a unit at its first word.
module neural_frame_gate #(
    parameter int          FRAME_WORDS = 304,
    parameter logic [63:0] MAGIC       = 64'hC691199927021942
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        fifo_prog_full,
    output logic [15:0] out_data,
    output logic        out_wen,
    output logic        locked,
    output logic        sync_error,
    output logic [15:0] frames_passed,
    output logic [15:0] frames_dropped
);

    localparam int CW = $clog2(FRAME_WORDS);
    localparam logic [3:0][15:0] MAGIC_W = MAGIC;

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state;
    logic [CW-1:0]    word_cnt;
    logic [2:0][15:0] hist;       // hist[0] is the most recent valid word
    logic             pass_cur;
    logic             pass_next;
    logic             hunt_hit;
    logic             hdr_bad;
    logic             frame_start;

    // The current word plus three history words form the 4-word header window.
    assign hunt_hit = (hist[2] == MAGIC_W[0]) && (hist[1] == MAGIC_W[1]) &&
                      (hist[0] == MAGIC_W[2]) && (in_data == MAGIC_W[3]);

    assign hdr_bad     = (state == LOCKED) && (word_cnt < CW'(4)) &&
                         (in_data != MAGIC_W[word_cnt[1:0]]);
    assign frame_start = (state == LOCKED) && (word_cnt == '0) && !hdr_bad;

    // Admission is decided combinationally at word 0 so that word itself is written.
    always_comb begin
        pass_next = pass_cur;
        if (in_valid) begin
            if (state != LOCKED || hdr_bad)
                pass_next = 1'b0;
            else if (word_cnt == '0)
                pass_next = enable & ~fifo_prog_full;
        end
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state          <= HUNT;
            word_cnt       <= '0;
            hist           <= '0;
            pass_cur       <= 1'b0;
            out_data       <= '0;
            out_wen        <= 1'b0;
            sync_error     <= 1'b0;
            frames_passed  <= '0;
            frames_dropped <= '0;
        end else begin
            out_wen  <= in_valid & pass_next;
            pass_cur <= pass_next;
            if (in_valid) begin
                out_data <= in_data;
                hist     <= {hist[1:0], in_data};
                case (state)
                    HUNT: begin
                        if (hunt_hit) begin
                            state    <= LOCKED;
                            word_cnt <= CW'(4);
                        end
                    end
                    LOCKED: begin
                        if (hdr_bad) begin
                            state      <= HUNT;
                            sync_error <= 1'b1;
                            word_cnt   <= '0;
                        end else begin
                            word_cnt <= (word_cnt == CW'(FRAME_WORDS - 1)) ? '0 : word_cnt + 1'b1;
                            if (frame_start && enable) begin
                                if (fifo_prog_full) begin
                                    if (frames_dropped != 16'hFFFF)
                                        frames_dropped <= frames_dropped + 16'd1;
                                end else begin
                                    if (frames_passed != 16'hFFFF)
                                        frames_passed <= frames_passed + 16'd1;
                                end
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neural_frame_gate.sv
// Directed bench for neural_frame_gate: expected FIFO writes are queued as words are driven
// and matched (data and cycle) whenever out_wen is seen.
module tb_neural_frame_gate;

    localparam int FW = 304;

    logic        dataclk = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        fifo_prog_full = 1'b0;
    logic [15:0] out_data;
    logic        out_wen;
    logic        locked;
    logic        sync_error;
    logic [15:0] frames_passed;
    logic [15:0] frames_dropped;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic vld_d  = 1'b0;
    bit   sparse = 1'b0;

    neural_frame_gate #(.FRAME_WORDS(FW), .MAGIC(64'hC691199927021942)) dut (
        .dataclk(dataclk), .reset(reset), .enable(enable), .in_data(in_data),
        .in_valid(in_valid), .fifo_prog_full(fifo_prog_full), .out_data(out_data),
        .out_wen(out_wen), .locked(locked), .sync_error(sync_error),
        .frames_passed(frames_passed), .frames_dropped(frames_dropped)
    );

    always #5 dataclk = ~dataclk;

    always @(posedge dataclk) begin
        cyc   <= cyc + 1;
        vld_d <= in_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] frame_word(input int fid, input int i);
        logic [63:0] m;
        m = 64'hC691199927021942;
        if (i < 4) return m[i*16 +: 16];
        return 16'((fid << 9) ^ i);
    endfunction

    task automatic send_word(input logic [15:0] d, input bit exp_wr);
        exp_t e;
        if (sparse) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 12)) begin
                @(posedge dataclk); #1;
            end
        end
        in_data  = d;
        in_valid = 1'b1;
        if (exp_wr) begin
            e.data = d;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge dataclk); #1;
        in_valid = 1'b0;
    endtask

    // Sends words [first..last] of frame fid; word bad_idx (if >= 0) is replaced by bad_val.
    task automatic send_frame(input int fid, input int first, input int last, input bit pass,
                              input int bad_idx = -1, input logic [15:0] bad_val = '0);
        for (int i = first; i <= last; i++) begin
            if (i == bad_idx) send_word(bad_val, 1'b0);
            else              send_word(frame_word(fid, i), pass && (bad_idx < 0 || i < bad_idx));
        end
    endtask

    task automatic lock_frame(input int fid);
        send_frame(fid, 0, 2, 1'b0);
        check("locked_before_c691", locked, 1'b0);
        send_frame(fid, 3, 3, 1'b0);
        check("locked_on_c691", locked, 1'b1);
        send_frame(fid, 4, FW - 1, 1'b0);
    endtask

    initial begin
        fork
            forever begin
                exp_t e;
                @(negedge dataclk);
                if (out_wen === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("unexpected_write", {16'h0, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("wdata", out_data, e.data);
                        check("wcycle", cyc, e.cyc);
                        check("wen_after_idle", vld_d, 1'b1);
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge dataclk);
        #1;
        check("rst_wen", out_wen, 0);
        check("rst_locked", locked, 0);
        check("rst_sync", sync_error, 0);
        check("rst_passed", frames_passed, 0);
        check("rst_dropped", frames_dropped, 0);
        reset = 1'b0;

        // Lock and pass
        for (int i = 0; i < 150; i++) send_word(16'($urandom), 1'b0);
        lock_frame(0);
        send_frame(1, 0, FW - 1, 1'b1);
        send_frame(2, 0, FW - 1, 1'b1);
        check("passed_after_lock", frames_passed, 2);

        // Backpressure drop; prog_full rising mid-frame does not truncate
        fifo_prog_full = 1'b1;
        send_frame(3, 0, 149, 1'b0);
        fifo_prog_full = 1'b0;
        send_frame(3, 150, FW - 1, 1'b0);
        send_frame(4, 0, FW - 1, 1'b1);
        check("dropped_one", frames_dropped, 1);
        send_frame(5, 0, 149, 1'b1);
        fifo_prog_full = 1'b1;
        send_frame(5, 150, FW - 1, 1'b1);
        fifo_prog_full = 1'b0;
        check("passed_bp", frames_passed, 4);

        // Enable gating
        send_frame(6, 0, 99, 1'b1);
        enable = 1'b0;
        send_frame(6, 100, FW - 1, 1'b1);
        send_frame(7, 0, 199, 1'b0);
        enable = 1'b1;
        send_frame(7, 200, FW - 1, 1'b0);
        send_frame(8, 0, FW - 1, 1'b1);
        check("passed_en", frames_passed, 6);
        check("dropped_en", frames_dropped, 1);

        // Header corruption on the third header word
        send_frame(9, 0, FW - 1, 1'b1, 2, 16'h1998);
        check("sync_err_set", sync_error, 1);
        check("unlocked_bad_hdr", locked, 0);
        lock_frame(10);
        send_frame(11, 0, FW - 1, 1'b1);
        check("sync_err_sticky", sync_error, 1);
        check("passed_relock", frames_passed, 8);

        // Reset mid-frame
        send_frame(12, 0, 50, 1'b1);
        @(negedge dataclk); #1;
        reset = 1'b1;
        #1;
        check("midrst_wen", out_wen, 0);
        check("midrst_passed", frames_passed, 0);
        check("midrst_dropped", frames_dropped, 0);
        check("midrst_sync", sync_error, 0);
        check("midrst_locked", locked, 0);
        check("midrst_sb_empty", sb.size(), 0);
        @(posedge dataclk); #1;
        reset = 1'b0;
        send_frame(12, 51, FW - 1, 1'b0);
        lock_frame(13);
        send_frame(14, 0, FW - 1, 1'b1);
        check("passed_after_rst", frames_passed, 1);

        // Sparse valid
        sparse = 1'b1;
        send_frame(15, 0, FW - 1, 1'b1);
        send_frame(16, 0, FW - 1, 1'b1);
        sparse = 1'b0;
        repeat (4) @(posedge dataclk);
        #1;
        check("passed_sparse", frames_passed, 3);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
